// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 UART transmitter (LSB first, idle-high line) fed by a
// small circular byte FIFO. Frames are sent back-to-back while bytes are queued.
//
// Handshake: a byte is written on any posedge where tx_valid && tx_ready.
// The producer holds tx_valid and tx_data stable until that edge. tx_ready
// is simply "FIFO not full", and it never depends on tx_valid.
module uart_tx_8n1 #(
  parameter int BAUD_TICKS = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx,
  output logic                             busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [1:0]                       dbg_state
);

  localparam int CW = $clog2(BAUD_TICKS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] LAST_TICK = CW'(BAUD_TICKS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_done;

  logic          w_push;
  logic          w_pop;
  logic          w_fifo_empty;
  logic          w_tick_end;

  assign w_fifo_empty = (r_level == '0);
  assign w_tick_end   = (r_cnt == LAST_TICK);
  assign w_push       = tx_valid && tx_ready;
  // The head is consumed when idle, or at the very end of a stop bit so the
  // next start bit follows with no idle gap.
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick_end));

  assign tx_ready   = (r_level != FULL_LVL);
  assign tx         = r_tx;
  assign tx_done    = r_done;
  assign fifo_level = r_level;
  assign busy       = (r_state != S_IDLE) || !w_fifo_empty;
  assign dbg_state  = r_state;

  // FIFO storage: written on an accepted handshake, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a push and pop together keep the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  // Frame FSM: start bit, 8 data bits LSB first, stop bit, each BAUD_TICKS long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick_end) begin
            r_cnt     <= '0;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick_end) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed bench for uart_tx_8n1 with BAUD_TICKS=8, FIFO_DEPTH=4.
// A line decoder turns tx back into bytes and compares them against a queue
// filled by the driver at each accepted handshake.
module tb_uart_tx_8n1;

  localparam int BT = 8;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_level;
  logic [1:0] dbg_state;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  bit saw_full = 1'b0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_8n1 #(.BAUD_TICKS(BT), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count tx_done pulses (value seen just before each edge).
  always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tx_ready must mirror "FIFO not full" at all times.
  always @(negedge clk) begin
    check("ready_vs_level", tx_ready, (fifo_level != 3'(FD)));
    if (fifo_level == 3'(FD)) saw_full = 1'b1;
  end

  // Driver: called at a negedge; returns at the negedge after the write edge.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("ready_timeout", (w < 2000), 1);
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", (w < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Line decoder: samples mid-bit, checks framing and the tx_done timing.
  initial begin : line_monitor
    logic [7:0] rx;
    @(negedge clk);
    forever begin
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (3) @(negedge clk);
        check("start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BT) @(negedge clk);
          rx[i] = tx;
        end
        repeat (BT) @(negedge clk);
        check("stop_bit", tx, 1);
        repeat (4) @(negedge clk);
        check("done_not_early", tx_done, 0);
        @(negedge clk);
        check("done_at_80", tx_done, 1);
        check("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rx_byte", rx, exp_q.pop_front());
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : stimulus
    int d0;
    int w;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_done", tx_done, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", tx_ready, 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 1: single 0x55 frame.
    d0 = done_cnt;
    send_byte(8'h55);
    check("t1_tx_before_fall", tx, 1);
    check("t1_busy_queued", busy, 1);
    check("t1_level_one", fifo_level, 1);
    @(negedge clk);
    check("t1_tx_fall", tx, 0);
    check("t1_level_popped", fifo_level, 0);
    check("t1_busy_frame", busy, 1);
    w = 0;
    while (tx_done !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("t1_done_seen", (w < 200), 1);
    check("t1_busy_low_at_done", busy, 0);
    @(negedge clk);
    check("t1_done_one_clock", tx_done, 0);
    check("t1_busy_after", busy, 0);
    wait_idle();
    check("t1_done_count", done_cnt - d0, 1);

    // 2: back-to-back frames.
    start_q.delete();
    d0 = done_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    wait_idle();
    check("t2_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("t2_gap_01", start_q[1] - start_q[0], 80);
      check("t2_gap_12", start_q[2] - start_q[1], 80);
    end
    check("t2_done_count", done_cnt - d0, 3);

    // 3: six held bytes, FIFO fills.
    d0 = done_cnt;
    saw_full = 1'b0;
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    send_byte(8'h67);
    send_byte(8'h89);
    send_byte(8'hAB);
    wait_idle();
    check("t3_saw_full", saw_full, 1);
    check("t3_done_count", done_cnt - d0, 6);

    // 4: reset in the middle of the first of three frames.
    mon_en = 1'b0;
    d0 = done_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_tx_high", tx, 1);
    check("t4_level_zero", fifo_level, 0);
    check("t4_ready", tx_ready, 1);
    check("t4_busy", busy, 0);
    check("t4_done_low", tx_done, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_line_idle", tx, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_level_still_zero", fifo_level, 0);
    exp_q.delete();
    mon_en = 1'b1;
    send_byte(8'h3C);
    wait_idle();
    check("t4_done_after_release", done_cnt - d0, 1);

    // 5: 256 random bytes through the decoder.
    d0 = done_cnt;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    wait_idle();
    check("t5_done_count", done_cnt - d0, 256);

    // 6: tx_data wiggles without tx_valid during a frame.
    d0 = done_cnt;
    send_byte(8'hC3);
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      check("t6_level", fifo_level, 0);
    end
    wait_idle();
    check("t6_done_count", done_cnt - d0, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
